toggle_detect_variable_width: RTL and testbench

- Receive end of the toggle-signalling scheme: each bit of tog_in is a level that flips once per event, driven by a toggle register, possibly in another clock domain.
- Synchronizes each bit into clk and converts every observed toggle into a one-cycle pulse.
- Holds each event as a pending flag until the consumer acks it.
- Flags an overrun when a second event arrives before the first is acked.

---
 rtl/toggle_detect_variable_width_if.sv | 23 ++
 rtl/toggle_detect_variable_width.sv | 112 +++++++++++
 tb/tb_toggle_detect_variable_width.sv | 136 +++++++++++++
 3 files changed

// File: rtl/toggle_detect_variable_width_if.sv
// Signal bundle for the toggle detector: toggle levels, consumer strobes and the
// per-channel event outputs. The detector uses the slave modport.
interface toggle_detect_variable_width_if #(
    parameter int WIDTH = 1
) ();
    logic [WIDTH-1:0] tog_in;
    logic [WIDTH-1:0] ack;
    logic [WIDTH-1:0] ovr_clr;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] overrun;
    logic             ready;

    modport master (
        output tog_in, ack, ovr_clr,
        input  pulse, pending, overrun, ready
    );

    modport slave (
        input  tog_in, ack, ovr_clr,
        output pulse, pending, overrun, ready
    );
endinterface

// File: rtl/toggle_detect_variable_width.sv
// Toggle-signalling receiver: synchronizes each toggle level, turns every flip into
// a one-cycle pulse, and latches it as pending (with sticky overrun) until acked.
//
//   state    | meaning
//   ST_RESET | held in reset; everything cleared
//   ST_PRIME | sync chain and prev settle on the transmitter level; detection masked
//   ST_RUN   | detection active, ready=1
module toggle_detect_variable_width #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               sres,
    toggle_detect_variable_width_if.slave      bus
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ovr_q, ovr_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] evt;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign evt      = sync_out ^ prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        pulse_d = '0;
        pend_d  = '0;
        ovr_d   = '0;

        sync_d[0] = bus.tog_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        case (state_q)
            ST_RESET: begin
                state_d = ST_PRIME;
                cnt_d   = CNT_W'(SYNC_STAGES);
            end
            ST_PRIME: begin
                // Down-count covers SYNC_STAGES+1 cycles so prev matches the settled level
                prev_d = sync_out;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                prev_d  = sync_out;
                pulse_d = evt;
                pend_d  = evt | (pend_q & ~bus.ack);
                // A simultaneous ack consumes the old event, so only an un-acked hit overruns
                ovr_d   = (evt & pend_q & ~bus.ack) | (ovr_q & ~bus.ovr_clr);
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (sres) begin
            state_q <= ST_RESET;
            cnt_q   <= CNT_W'(SYNC_STAGES);
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q  <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ready_q <= ready_d;
        end
    end

    assign bus.pulse   = pulse_q;
    assign bus.pending = pend_q;
    assign bus.overrun = ovr_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_toggle_detect_variable_width.sv
// Directed bench for toggle_detect_variable_width (WIDTH=4, SYNC_STAGES=2):
// a vector table for bring-up and single events, then hand sequences for corner cases.
module tb_toggle_detect_variable_width;
    logic clk = 1'b0;
    logic sres;

    always #5 clk = ~clk;

    toggle_detect_variable_width_if #(.WIDTH(4)) bus ();

    toggle_detect_variable_width #(
        .WIDTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk (clk),
        .sres(sres),
        .bus (bus)
    );

    typedef struct {
        logic       sres;
        logic [3:0] tog;
        logic [3:0] ack;
        logic [3:0] clr;
        logic [3:0] e_pulse;
        logic [3:0] e_pend;
        logic [3:0] e_ovr;
        logic       e_rdy;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, then settle away from the edge.
    task automatic step(input logic s, input logic [3:0] t, input logic [3:0] a, input logic [3:0] c);
        sres        = s;
        bus.tog_in  = t;
        bus.ack     = a;
        bus.ovr_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int idx, input logic [3:0] p, input logic [3:0] pe,
                              input logic [3:0] o, input logic r);
        chk("pulse",   idx, bus.pulse,   p);
        chk("pending", idx, bus.pending, pe);
        chk("overrun", idx, bus.overrun, o);
        chk("ready",   idx, {3'b000, bus.ready}, {3'b000, r});
    endtask

    task automatic add(input logic s, input logic [3:0] t, input logic [3:0] a, input logic [3:0] c,
                       input logic [3:0] p, input logic [3:0] pe, input logic [3:0] o, input logic r);
        vec_t v;
        v.sres = s; v.tog = t; v.ack = a; v.clr = c;
        v.e_pulse = p; v.e_pend = pe; v.e_ovr = o; v.e_rdy = r;
        vq.push_back(v);
    endtask

    initial begin
        sres        = 1'b1;
        bus.tog_in  = 4'b1010;
        bus.ack     = 4'b0000;
        bus.ovr_clr = 4'b0000;

        //   sres tog      ack      clr      pulse    pend     ovr      rdy
        add(1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // leave RESET
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1); // ready after 1+3
        add(0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1); // e0: flip bit0
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1); // e0+2
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1);
        add(0, 4'b1011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1); // ack bit0
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1); // ack while idle
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1); // f0: flip bit2
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1); // f0+5: flip bit2
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 1); // overrun
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1);
        add(0, 4'b1011, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1); // ovr_clr
        add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].sres, vq[i].tog, vq[i].ack, vq[i].clr);
            expect_out(i, vq[i].e_pulse, vq[i].e_pend, vq[i].e_ovr, vq[i].e_rdy);
        end

        // ovr_clr on the same edge as a new overrun: set wins
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(100, 4'b0000, 4'b0100, 4'b0000, 1);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(101, 4'b0000, 4'b0100, 4'b0000, 1);
        step(0, 4'b1111, 4'b0000, 4'b0100); expect_out(102, 4'b0100, 4'b0100, 4'b0100, 1);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(103, 4'b0000, 4'b0100, 4'b0100, 1);

        // second event on bit1 coincides with ack[1]: pending stays, no overrun
        step(0, 4'b1101, 4'b0000, 4'b0000); expect_out(200, 4'b0000, 4'b0100, 4'b0100, 1);
        step(0, 4'b1101, 4'b0000, 4'b0000); expect_out(201, 4'b0000, 4'b0100, 4'b0100, 1);
        step(0, 4'b1101, 4'b0000, 4'b0000); expect_out(202, 4'b0010, 4'b0110, 4'b0100, 1);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(203, 4'b0000, 4'b0110, 4'b0100, 1);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(204, 4'b0000, 4'b0110, 4'b0100, 1);
        step(0, 4'b1111, 4'b0010, 4'b0000); expect_out(205, 4'b0010, 4'b0110, 4'b0100, 1);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(206, 4'b0000, 4'b0110, 4'b0100, 1);

        // one-cycle reset mid-operation, then re-prime against a nonzero level
        step(1, 4'b1111, 4'b0000, 4'b0000); expect_out(300, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(301, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(302, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(303, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b1111, 4'b0000, 4'b0000); expect_out(304, 4'b0000, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1111, 4'b0000, 4'b0000);
            expect_out(305 + i, 4'b0000, 4'b0000, 4'b0000, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
